vga_pll_reset_sequencer: RTL and testbench

//  Sequences the VGA pixel-clock PLL: pulses its reset, waits for lock with timeout and retry,

---
 rtl/vga_pll_reset_sequencer.sv | 137 +++++++++++++
 tb/tb_vga_pll_reset_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_pll_reset_sequencer.sv
// PLL reset/lock sequencer for the VGA pixel clock: pulses the PLL reset, waits for and
// qualifies lock with timeout/retry, then releases the downstream system reset.
module vga_pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20,
    parameter int RETRY_W             = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               restart,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [7:0]         lock_loss_count
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BLANK_CYC   = CNT_W'(3);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [RETRY_W:0]   RETRY_LIMIT = (RETRY_W + 1)'(MAX_RETRIES);
    localparam logic [RETRY_W:0]   RETRY_ONE   = (RETRY_W + 1)'(1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         loss_q, loss_d;
    logic               meta_q, locked_s_q;
    logic               pll_rst_q, sys_reset_q, ready_q, fault_q;
    logic               fail;
    logic [RETRY_W:0]   retry_inc;

    assign retry_inc = {1'b0, retry_q} + RETRY_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        retry_d = retry_q;
        loss_d  = loss_q;
        fail    = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // First cycles after the PLL reset see stale synchroniser contents.
                if (cnt_q >= BLANK_CYC && locked_s_q) state_d = S_STABLE;
                else if (cnt_q == TIMEOUT_LAST)       fail    = 1'b1;
            end
            S_STABLE: begin
                if (!locked_s_q)                fail    = 1'b1;
                else if (cnt_q == STABLE_LAST)  state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s_q) begin
                    state_d = S_PLL_RST;
                    loss_d  = sat_inc8(loss_q);
                end
            end
            S_FAULT: begin
                cnt_d = cnt_q;
            end
            default: state_d = S_PLL_RST;
        endcase

        if (fail) begin
            if (retry_inc == RETRY_LIMIT) begin
                state_d = S_FAULT;
                retry_d = RETRY_LIMIT[RETRY_W-1:0];
            end else begin
                state_d = S_PLL_RST;
                retry_d = retry_inc[RETRY_W-1:0];
            end
        end
        if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
        if (restart) begin
            state_d = S_PLL_RST;
            retry_d = '0;
        end
        if (state_d != state_q || restart) cnt_d = '0;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            meta_q      <= 1'b0;
            locked_s_q  <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            meta_q      <= pll_locked;
            locked_s_q  <= meta_q;
            // Outputs decoded from next state so they move on the same edge as the FSM.
            pll_rst_q   <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
            sys_reset_q <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_vga_pll_reset_sequencer.sv
// Directed bench for vga_pll_reset_sequencer with small timing parameters.
module tb_vga_pll_reset_sequencer;

    localparam int RP = 4, TO = 20, ST = 8, MR = 2, CW = 20, RW = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1, restart = 1'b0, pll_locked = 1'b0;
    logic          pll_rst, sys_reset, ready, fault;
    logic [RW-1:0] retry_count;
    logic [7:0]    lock_loss_count;

    vga_pll_reset_sequencer #(
        .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(ST),
        .MAX_RETRIES(MR), .CNT_W(CW), .RETRY_W(RW)
    ) dut (
        .refclk(refclk), .rst(rst), .restart(restart), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .fault(fault),
        .retry_count(retry_count), .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int   n;
        logic r, rs, lk;
        logic pr, sr, rd, ft;
        int   rc, ll;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int n, input logic r, rs, lk, pr, sr, rd, ft, input int rc, ll);
        vec_t v;
        v.n = n; v.r = r; v.rs = rs; v.lk = lk;
        v.pr = pr; v.sr = sr; v.rd = rd; v.ft = ft; v.rc = rc; v.ll = ll;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic wait_ready(input logic val, input int limit);
        int c;
        c = 0;
        while (ready !== val && c < limit) begin
            step(1);
            c++;
        end
    endtask

    task automatic chk_all(input string tag, input logic pr, sr, rd, ft, input int rc, ll);
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(pr));
        chk({tag, ".sys_reset"}, 32'(sys_reset), 32'(sr));
        chk({tag, ".ready"}, 32'(ready), 32'(rd));
        chk({tag, ".fault"}, 32'(fault), 32'(ft));
        chk({tag, ".retry"}, 32'(retry_count), rc);
        chk({tag, ".lock_loss"}, 32'(lock_loss_count), ll);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_ll;

        //   n   r  rs lk   pr sr rd ft rc ll
        add( 2, 1, 0, 0,   1, 1, 0, 0, 0, 0);  // reset values
        add( 3, 0, 0, 0,   1, 1, 0, 0, 0, 0);  // pll_rst pulse continues
        add( 1, 0, 0, 0,   0, 1, 0, 0, 0, 0);  // 4th cycle: WAIT_LOCK
        add( 6, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        add(10, 0, 0, 1,   0, 1, 0, 0, 0, 0);  // lock edge, 10 cycles later still held
        add( 1, 0, 0, 1,   0, 0, 1, 0, 0, 0);  // 11th cycle: RUN
        add( 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);  // lock drop, synchroniser delay
        add( 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        add( 1, 0, 0, 0,   1, 1, 0, 0, 0, 1);  // back to PLL_RST, one loss
        add( 4, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        add(19, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        add( 1, 0, 0, 0,   1, 1, 0, 0, 1, 1);  // first timeout
        add( 4, 0, 0, 0,   0, 1, 0, 0, 1, 1);
        add(19, 0, 0, 0,   0, 1, 0, 0, 1, 1);
        add( 1, 0, 0, 0,   1, 1, 0, 1, 2, 1);  // second timeout: FAULT
        add( 5, 0, 0, 0,   1, 1, 0, 1, 2, 1);
        add( 1, 0, 1, 0,   1, 1, 0, 0, 0, 1);  // restart clears fault
        add( 3, 0, 0, 0,   1, 1, 0, 0, 0, 1);
        add( 1, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        add( 4, 0, 0, 1,   0, 1, 0, 0, 0, 1);  // lock -> STABLE after blanking
        add( 3, 0, 0, 1,   0, 1, 0, 0, 0, 1);
        add( 1, 0, 0, 0,   0, 1, 0, 0, 0, 1);  // one-cycle glitch
        add( 1, 0, 0, 1,   0, 1, 0, 0, 0, 1);
        add( 1, 0, 0, 1,   1, 1, 0, 0, 1, 1);  // glitch seen: attempt failure
        add( 3, 0, 0, 1,   1, 1, 0, 0, 1, 1);
        add( 1, 0, 0, 1,   0, 1, 0, 0, 1, 1);
        add(11, 0, 0, 1,   0, 1, 0, 0, 1, 1);
        add( 1, 0, 0, 1,   0, 0, 1, 0, 0, 1);  // RUN clears retry_count

        for (int i = 0; i < tbl.size(); i++) begin
            rst        = tbl[i].r;
            restart    = tbl[i].rs;
            pll_locked = tbl[i].lk;
            step(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].pr, tbl[i].sr, tbl[i].rd, tbl[i].ft,
                    tbl[i].rc, tbl[i].ll);
        end
        rst = 1'b0; restart = 1'b0;

        // Repeated lock loss in RUN, lock_loss_count saturates.
        exp_ll = 1;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(3);
            exp_ll = (exp_ll == 255) ? 255 : exp_ll + 1;
            chk($sformatf("loss%0d.ready", i), 32'(ready), 0);
            chk($sformatf("loss%0d.sys_reset", i), 32'(sys_reset), 1);
            chk($sformatf("loss%0d.count", i), 32'(lock_loss_count), exp_ll);
            pll_locked = 1'b1;
            wait_ready(1'b1, 60);
            chk($sformatf("loss%0d.relock", i), 32'(ready), 1);
        end
        chk("loss_saturated", 32'(lock_loss_count), 255);

        // Restart from RUN with lock held, then rst while in STABLE.
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk_all("restart_run", 1, 1, 0, 0, 0, 255);
        step(9);
        chk_all("in_stable", 0, 1, 0, 0, 0, 255);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_all("rst_stable", 1, 1, 0, 0, 0, 0);
        wait_ready(1'b1, 60);
        chk("rst_recover.ready", 32'(ready), 1);

        // Restart coincident with the cycle that sees lock loss in RUN.
        pll_locked = 1'b0;
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk_all("restart_loss", 1, 1, 0, 0, 0, 1);

        // Lock arrives on the timeout cycle: lock wins.
        step(4);
        chk("tie.wait_lock", 32'(pll_rst), 0);
        step(17);
        pll_locked = 1'b1;
        step(3);
        chk_all("tie_lock_wins", 0, 1, 0, 0, 0, 1);
        step(8);
        chk_all("tie_run", 0, 0, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
